// File: rtl/spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_mc
// Brief    : CS-framed SPI master, write phase then read phase, all four
//            CPOL/CPHA modes, programmable SCK divider and byte depth.
// Revision : 1.0
// ============================================================================
module spi_master_mc #(
    parameter int MAX_BYTES = 4,
    parameter int CLK_DIV   = 4,
    parameter int CW        = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start,
    input  logic                   cpol,
    input  logic                   cpha,
    input  logic [CW-1:0]          wr_count,
    input  logic [CW-1:0]          rd_count,
    input  logic [MAX_BYTES*8-1:0] wr_data,
    output logic [MAX_BYTES*8-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   sck,
    output logic                   mosi,
    input  logic                   miso,
    output logic                   cs_n
);
    localparam int c_DW   = MAX_BYTES * 8;
    localparam int c_EW   = $clog2(32 * MAX_BYTES + 1);
    localparam int c_DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETUP  = 3'd1;
    localparam logic [2:0] c_ST_SHIFT  = 3'd2;
    localparam logic [2:0] c_ST_HOLD   = 3'd3;
    localparam logic [2:0] c_ST_FINISH = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [c_DIVW-1:0] r_div;
    logic [c_EW-1:0]   r_edge;
    logic [c_EW-1:0]   r_wr_bits;
    logic [c_EW-1:0]   r_total_edges;
    logic              r_sck;
    logic              r_cpha;
    logic [c_DW-1:0]   r_wr_data;
    logic [c_DW-1:0]   r_rd_data;

    logic [CW-1:0]     w_wr_clamp;
    logic [CW-1:0]     w_rd_clamp;
    logic [c_EW-1:0]   w_wr_bits_in;
    logic [c_EW-1:0]   w_total_in;
    logic [c_EW-1:0]   w_tx_idx;
    logic [c_EW-1:0]   w_tx_pos;
    logic [c_EW-1:0]   w_rx_idx;
    logic [c_DW-1:0]   w_tx_mask;
    logic              w_accept;
    logic              w_active;
    logic              w_tick;
    logic              w_last_edge;
    logic              w_sample;

    assign w_wr_clamp   = (wr_count > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : wr_count;
    assign w_rd_clamp   = (rd_count > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : rd_count;
    assign w_wr_bits_in = c_EW'(w_wr_clamp) << 3;
    assign w_total_in   = (c_EW'(w_wr_clamp) + c_EW'(w_rd_clamp)) << 4;

    assign w_accept    = start && (r_state == c_ST_IDLE);
    assign w_active    = (r_state == c_ST_SETUP) || (r_state == c_ST_SHIFT) ||
                         (r_state == c_ST_HOLD);
    assign w_tick      = (r_div == c_DIVW'(CLK_DIV - 1));
    assign w_last_edge = (r_edge == r_total_edges - c_EW'(1));

    // Even edge count = leading edge next; cpha selects which parity samples.
    assign w_sample  = (r_state == c_ST_SHIFT) && w_tick && (r_edge[0] == r_cpha);
    assign w_rx_idx  = r_edge >> 1;
    // cpha=1 launches on leading edges, so the presented bit lags by one edge.
    assign w_tx_idx  = (r_cpha && (r_edge != '0)) ? ((r_edge - c_EW'(1)) >> 1)
                                                  : (r_edge >> 1);
    assign w_tx_pos  = r_wr_bits - w_tx_idx - c_EW'(1);
    assign w_tx_mask = c_DW'(1) << w_tx_pos;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_total_in == '0) ? c_ST_FINISH : c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                if (w_tick) w_next_state = c_ST_SHIFT;
            end
            c_ST_SHIFT: begin
                if (w_tick && w_last_edge) w_next_state = c_ST_HOLD;
            end
            c_ST_HOLD: begin
                if (w_tick) w_next_state = c_ST_FINISH;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        cs_n = 1'b1;
        busy = 1'b0;
        done = 1'b0;
        mosi = 1'b0;
        case (r_state)
            c_ST_SETUP, c_ST_SHIFT: begin
                cs_n = 1'b0;
                busy = 1'b1;
                mosi = (w_tx_idx < r_wr_bits) && (|(r_wr_data & w_tx_mask));
            end
            c_ST_HOLD: begin
                cs_n = 1'b0;
                busy = 1'b1;
            end
            c_ST_FINISH: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_div         <= '0;
            r_edge        <= '0;
            r_wr_bits     <= '0;
            r_total_edges <= '0;
            r_sck         <= 1'b0;
            r_cpha        <= 1'b0;
            r_wr_data     <= '0;
            r_rd_data     <= '0;
        end else begin
            r_div <= (w_active && !w_tick) ? r_div + c_DIVW'(1) : '0;
            if (w_accept) begin
                r_cpha        <= cpha;
                r_sck         <= cpol;
                r_wr_bits     <= w_wr_bits_in;
                r_total_edges <= w_total_in;
                r_wr_data     <= wr_data;
                r_rd_data     <= '0;
                r_edge        <= '0;
            end else if ((r_state == c_ST_SHIFT) && w_tick) begin
                r_sck  <= ~r_sck;
                r_edge <= r_edge + c_EW'(1);
                // Shifting into a cleared register leaves the first read bit at rd_count*8-1.
                if (w_sample && (w_rx_idx >= r_wr_bits)) begin
                    r_rd_data <= {r_rd_data[c_DW-2:0], miso};
                end
            end
        end
    end

    assign sck     = r_sck;
    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_mc
// Brief    : Scoreboard bench for spi_master_mc with an SPI slave model.
// Revision : 1.0
// ============================================================================
module tb_spi_master_mc;
    localparam int MB = 4;
    localparam int CD = 2;
    localparam int CW = 3;

    typedef struct {
        logic [31:0] rd;
        int          busy_cyc;
        int          edges;
        int          nbits;
        logic [63:0] mosi_exp;
        logic [63:0] sbits;
        bit          cpol;
        bit          cpha;
    } exp_t;

    logic          clk;
    logic          rst_in;
    logic          start;
    logic          cpol;
    logic          cpha;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] rd_count;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic          busy;
    logic          done;
    logic          sck;
    logic          mosi;
    logic          miso;
    logic          cs_n;

    spi_master_mc #(.MAX_BYTES(MB), .CLK_DIV(CD)) dut (
        .clk_in   (clk),
        .rst_in   (rst_in),
        .start    (start),
        .cpol     (cpol),
        .cpha     (cpha),
        .wr_count (wr_count),
        .rd_count (rd_count),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .cs_n     (cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_done   = 0;
    int          n_done_ref = 0;
    int          edges    = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    endtask

    // ---------------- monitor + slave model ----------------
    logic        prev_sck = 1'b0;
    bit          prev_idle = 1'b0;
    bit          in_txn = 1'b0;
    bit          accepted;
    bit          lead;
    int          lat, busy_cnt, cs_low, mosi_n, s_cnt;
    logic [63:0] mosi_sr;
    exp_t        e_cur;

    initial begin : monitor
        s_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_in) begin
                if (in_txn && sb.size() > 0) void'(sb.pop_front());
                in_txn = 1'b0;
                s_cnt  = 0;
            end else begin
                accepted = start && prev_idle;
                if (accepted) begin
                    in_txn = 1'b1; lat = 0; busy_cnt = 0; cs_low = 0;
                    edges = 0; mosi_sr = '0; mosi_n = 0;
                end else if (in_txn) begin
                    lat++;
                    if (sck !== prev_sck && sb.size() > 0) begin
                        edges++;
                        lead = (sck !== sb[0].cpol);
                        if (lead != sb[0].cpha) begin
                            mosi_sr = {mosi_sr[62:0], mosi};
                            mosi_n++;
                            s_cnt++;
                        end
                    end
                end
                if (in_txn) begin
                    if (busy) busy_cnt++;
                    if (!cs_n) cs_low++;
                end
                if (done) begin
                    if (!in_txn || sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e_cur = sb.pop_front();
                        check("rd_data",     rd_data,  e_cur.rd);
                        check("done_lat",    lat,      e_cur.busy_cyc);
                        check("busy_cycles", busy_cnt, e_cur.busy_cyc);
                        check("cs_low",      cs_low,   e_cur.busy_cyc);
                        check("sck_edges",   edges,    e_cur.edges);
                        check("mosi_bits",   mosi_sr,  e_cur.mosi_exp);
                        check("mosi_count",  mosi_n,   e_cur.nbits);
                        check("sck_idle",    sck,      e_cur.cpol);
                        in_txn = 1'b0;
                        n_done++;
                    end
                end
            end
            if (cs_n) s_cnt = 0;
            miso = (sb.size() > 0 && s_cnt < 64) ? sb[0].sbits[63 - s_cnt] : 1'b0;
            prev_sck  = sck;
            prev_idle = !busy && !done && !rst_in;
        end
    end

    // ---------------- stimulus ----------------
    task automatic launch(input bit pol, input bit pha, input int wr, input int rd,
                          input logic [31:0] wdata, input logic [31:0] resp,
                          input logic [31:0] exp_rd);
        exp_t e;
        int   we, re, n;
        we = (wr > MB) ? MB : wr;
        re = (rd > MB) ? MB : rd;
        n  = we + re;
        e.rd       = exp_rd;
        e.busy_cyc = (n == 0) ? 0 : CD * (2 + 16 * n);
        e.edges    = 16 * n;
        e.nbits    = 8 * n;
        e.mosi_exp = (64'(wdata) & ((64'd1 << (8 * we)) - 64'd1)) << (8 * re);
        e.sbits    = (n == 0) ? 64'd0 : (64'(resp) << (64 - 8 * n));
        e.cpol     = pol;
        e.cpha     = pha;
        sb.push_back(e);
        n_done_ref = n_done;
        @(negedge clk);
        cpol = pol; cpha = pha;
        wr_count = CW'(wr); rd_count = CW'(rd);
        wr_data = wdata; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 600 && n_done == n_done_ref; i++) @(negedge clk);
        check("done_timeout", n_done != n_done_ref, 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit saw_done;
        rst_in = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0;
        wr_count = '0; rd_count = '0; wr_data = '0; miso = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n",    cs_n,    1);
        check("rst_sck",     sck,     0);
        check("rst_mosi",    mosi,    0);
        check("rst_busy",    busy,    0);
        check("rst_done",    done,    0);
        check("rst_rd_data", rd_data, 0);
        @(negedge clk) rst_in = 1'b0;
        repeat (2) @(negedge clk);

        // four modes, same payload
        launch(0, 0, 1, 1, 32'h000000A5, 32'h3C, 32'h0000003C); wait_done();
        launch(0, 1, 1, 1, 32'h000000A5, 32'h3C, 32'h0000003C); wait_done();
        launch(1, 0, 1, 1, 32'h000000A5, 32'h3C, 32'h0000003C); wait_done();
        launch(1, 1, 1, 1, 32'h000000A5, 32'h3C, 32'h0000003C); wait_done();
        // full-depth write, partial-depth read
        launch(0, 0, 4, 0, 32'h11223344, 32'h0,      32'h00000000); wait_done();
        launch(0, 0, 0, 3, 32'h0,        32'hDEADBE, 32'h00DEADBE); wait_done();
        // zero counts: rd_data also cleared from the previous read
        launch(0, 0, 0, 0, 32'h55AA55AA, 32'h0,      32'h00000000); wait_done();
        // ignored start mid-transaction with changed inputs
        launch(1, 1, 2, 2, 32'h0000BEEF, 32'hCAFE,   32'h0000CAFE);
        repeat (20) @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; wr_count = 3'd1; rd_count = 3'd0;
        wr_data = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done();
        // count above MAX_BYTES clamps to MAX_BYTES
        launch(0, 0, 7, 0, 32'h01020304, 32'h0,      32'h00000000); wait_done();

        // reset at the 5th SCK edge
        launch(0, 0, 1, 1, 32'h000000A5, 32'h3C, 32'h0000003C);
        for (int i = 0; i < 200 && edges < 5; i++) @(negedge clk);
        check("rst_edge_reached", edges >= 5, 1);
        rst_in = 1'b1;
        @(posedge clk); #1;
        check("abort_cs_n", cs_n, 1);
        check("abort_sck",  sck,  0);
        check("abort_busy", busy, 0);
        @(negedge clk) rst_in = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        launch(0, 0, 1, 1, 32'h0000005A, 32'hC3, 32'h000000C3); wait_done();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
